systolic_array_ctrl: RTL
========================

// Module: systolic_array_ctrl
// PURPOSE
//  Sequencer for a SIZE x SIZE output-stationary array of Processing_Element instances.
//  - On start: clears the array, then streams skewed row/column read addresses to the A/B operand buffers.
//  - Drives the array-wide read (accumulate) and write (capture) strobes.
//  - Unloads results one row per cycle, then pulses done.
//  Sits between the host command interface and the array datapath; the operand buffers and PEs are external.
// PARAMETERS
//  SIZE    4   array dimension (rows = cols = SIZE), >=2
//  KW      8   width of k_len and of each buffer address
//  RD_LAT  1   operand-buffer read latency in cycles, >=1
// PORTS
//  clk       in   1        clock, all logic on rising edge
//  clr       in   1        synchronous active-high reset
//  start     in   1        begin a job; sampled only in IDLE
//  k_len     in   KW       inner dimension K; captured at accepted start
//  busy      out  1        high CLEAR..UNLOAD inclusive
//  done      out  1        one-cycle pulse at end of job
//  a_en      out  SIZE     per-row A read enable (row i = bit i)
//  a_addr    out  SIZE*KW  per-row A address; row i at [i*KW +: KW]
//  b_en      out  SIZE     per-column B read enable
//  b_addr    out  SIZE*KW  per-column B address; column j at [j*KW +: KW]
//  pe_clr    out  1        clear all PE accumulators
//  pe_read   out  1        PE accumulate/shift enable
//  pe_write  out  1        PE result capture strobe
//  out_valid out  1        out_row carries a valid unload row
//  out_row   out  $clog2(SIZE)  row index being unloaded
// BEHAVIOUR
//  - All outputs registered. Reset value of every output is 0; state returns to IDLE.
//  - clr has priority over everything, including mid-job: the job is abandoned, and no done pulse is issued.
//  - FSM: IDLE -> CLEAR -> FEED -> FLUSH -> WRITE -> UNLOAD -> DONE -> IDLE.
//  - IDLE: start=1 latches K=k_len; next state CLEAR.
//  - CLEAR: 1 cycle, pe_clr=1. Next state is FEED, or WRITE if K==0 (pe_read never asserted).
//  - FEED: T = K + 2*(SIZE-1) cycles, counter t = 0..T-1.
//    - Row i: a_en[i] = (i <= t < i+K); a_addr_i = t-i when enabled, else 0.
//    - Column j: b_en[j] and b_addr_j follow the same rule with j.
//  - pe_read: high for exactly T cycles, starting RD_LAT cycles after the first FEED cycle.
//    This aligns it with buffer data; the host zero-fills lanes whose enable was low.
//  - FLUSH: RD_LAT cycles; no enables; pe_read continues per the rule above.
//  - WRITE: 1 cycle, pe_write=1.
//  - UNLOAD: SIZE cycles; out_valid=1; out_row = 0,1,..,SIZE-1.
//  - DONE: 1 cycle; done=1, busy=0; next state IDLE. start is ignored in DONE and in every state except IDLE.
//  - k_len changes after start are ignored until the next accepted start.
//  - Counter width is KW+$clog2(SIZE)+1, so T never wraps.
//  - Latency, start at cycle c:
//    - CLEAR at c+1; FEED c+2..c+1+T; WRITE at c+2+T+RD_LAT.
//    - UNLOAD ends at c+2+T+RD_LAT+SIZE; done at c+3+T+RD_LAT+SIZE.
// STRUCTURE
//  - Package systolic_pkg: FSM state encoding, width localparams (row index width, counter width), T formula as a function.
//  - Sub-module systolic_skew_lane (params KW, LANE): combinational en/addr from t, K and lane index.
//    Instantiated 2*SIZE times (SIZE for A rows, SIZE for B columns); outputs registered in the top.
// TESTING
//  - SIZE=4, RD_LAT=1, K=4, start at c:
//    - pe_clr at c+1; a_en[0] c+2..c+5; a_en[3] c+5..c+8 with addr 0..3.
//    - pe_read c+3..c+12; pe_write c+13; out_row 0..3 at c+14..c+17; done c+18.
//  - K=0: CLEAR -> WRITE directly; a_en, b_en and pe_read never high; done 3+SIZE cycles after start.
//  - start held high through the whole job and into DONE: exactly one job and one done pulse; new job accepted only from IDLE.
//  - clr asserted during FEED (t=3): all outputs 0 next cycle, no done; a following start runs a clean full job.
//  - k_len changed from 4 to 9 in the cycle after start: the job still uses K=4 (T=10).
//  - K=255 (KW=8), SIZE=4: addresses reach 255 with no wrap; a_en[3] high exactly 255 cycles; T=261.

Source files
------------

// File: rtl/systolic_array_ctrl_pkg.sv
// Shared state encoding and width helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_WRITE,
        S_UNLOAD,
        S_DONE
    } state_t;

    function automatic int row_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Wide enough that the feed length plus flush never wraps.
    function automatic int cnt_w(input int kw, input int size);
        return kw + row_w(size) + 1;
    endfunction

    function automatic int feed_len(input int k, input int size);
        return k + 2 * (size - 1);
    endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Host command and array-datapath signal bundle for the sequencer.
interface systolic_array_ctrl_if #(
    parameter int SIZE = 4,
    parameter int KW   = 8
);
    localparam int RW = $clog2(SIZE);

    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 busy;
    logic                 done;
    logic [SIZE-1:0]      a_en;
    logic [SIZE*KW-1:0]   a_addr;
    logic [SIZE-1:0]      b_en;
    logic [SIZE*KW-1:0]   b_addr;
    logic                 pe_clr;
    logic                 pe_read;
    logic                 pe_write;
    logic                 out_valid;
    logic [RW-1:0]        out_row;

    modport master (
        input  start, k_len,
        output busy, done, a_en, a_addr, b_en, b_addr,
        output pe_clr, pe_read, pe_write, out_valid, out_row
    );

    modport slave (
        output start, k_len,
        input  busy, done, a_en, a_addr, b_en, b_addr,
        input  pe_clr, pe_read, pe_write, out_valid, out_row
    );

endinterface

// File: rtl/systolic_array_ctrl_skew_lane.sv
// One skewed operand lane: enable and address for a row or column at feed step t.
module systolic_skew_lane #(
    parameter int KW   = 8,
    parameter int CW   = KW + 3,
    parameter int LANE = 0
) (
    input  logic [CW-1:0] t,
    input  logic [KW-1:0] k,
    output logic          en,
    output logic [KW-1:0] addr
);

    logic [CW-1:0] rel;

    assign rel  = t - CW'(LANE);
    assign en   = (t >= CW'(LANE)) && (rel < CW'(k));
    assign addr = en ? rel[KW-1:0] : '0;

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an output-stationary SIZE x SIZE systolic array:
// clear, skewed operand feed, flush, capture, row unload, done.
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int KW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    systolic_array_ctrl_if.master bus
);

    localparam int CW = cnt_w(KW, SIZE);
    localparam int RW = row_w(SIZE);

    state_t             state, state_n;
    logic [CW-1:0]      t, t_n;
    logic [KW-1:0]      k_q;
    logic [CW-1:0]      t_last, f_last;
    logic               feed_n;
    logic [SIZE-1:0]    a_en_n, b_en_n;
    logic [SIZE*KW-1:0] a_addr_n, b_addr_n;

    // t keeps counting through FLUSH so pe_read is a single compare.
    assign t_last = CW'(feed_len(int'(k_q), SIZE) - 1);
    assign f_last = CW'(feed_len(int'(k_q), SIZE) + RD_LAT - 1);

    always_comb begin
        state_n = state;
        t_n     = t;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_CLEAR;
                    t_n     = '0;
                end
            end
            S_CLEAR: begin
                t_n     = '0;
                state_n = (k_q == '0) ? S_WRITE : S_FEED;
            end
            S_FEED: begin
                t_n = t + CW'(1);
                if (t == t_last) state_n = S_FLUSH;
            end
            S_FLUSH: begin
                if (t == f_last) begin
                    state_n = S_WRITE;
                    t_n     = '0;
                end else begin
                    t_n = t + CW'(1);
                end
            end
            S_WRITE: begin
                state_n = S_UNLOAD;
                t_n     = '0;
            end
            S_UNLOAD: begin
                if (t == CW'(SIZE - 1)) begin
                    state_n = S_DONE;
                    t_n     = '0;
                end else begin
                    t_n = t + CW'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign feed_n = (state_n == S_FEED);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic          ea, eb;
        logic [KW-1:0] aa, ab;

        systolic_skew_lane #(.KW(KW), .CW(CW), .LANE(i)) u_a (
            .t(t_n), .k(k_q), .en(ea), .addr(aa)
        );
        systolic_skew_lane #(.KW(KW), .CW(CW), .LANE(i)) u_b (
            .t(t_n), .k(k_q), .en(eb), .addr(ab)
        );

        assign a_en_n[i]            = ea & feed_n;
        assign b_en_n[i]            = eb & feed_n;
        assign a_addr_n[i*KW +: KW] = feed_n ? aa : '0;
        assign b_addr_n[i*KW +: KW] = feed_n ? ab : '0;
    end

    // Outputs are registered from next-state values so they line up with state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= S_IDLE;
            t             <= '0;
            k_q           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.a_en      <= '0;
            bus.a_addr    <= '0;
            bus.b_en      <= '0;
            bus.b_addr    <= '0;
            bus.pe_clr    <= 1'b0;
            bus.pe_read   <= 1'b0;
            bus.pe_write  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
        end else begin
            state <= state_n;
            t     <= t_n;
            if (state == S_IDLE && bus.start) k_q <= bus.k_len;
            bus.busy      <= state_n inside {S_CLEAR, S_FEED, S_FLUSH,
                                             S_WRITE, S_UNLOAD};
            bus.done      <= (state_n == S_DONE);
            bus.a_en      <= a_en_n;
            bus.a_addr    <= a_addr_n;
            bus.b_en      <= b_en_n;
            bus.b_addr    <= b_addr_n;
            bus.pe_clr    <= (state_n == S_CLEAR);
            bus.pe_read   <= (state_n == S_FEED || state_n == S_FLUSH)
                             && (t_n >= CW'(RD_LAT));
            bus.pe_write  <= (state_n == S_WRITE);
            bus.out_valid <= (state_n == S_UNLOAD);
            bus.out_row   <= (state_n == S_UNLOAD) ? t_n[RW-1:0] : '0;
        end
    end

endmodule
